// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine scheduler.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int GCD_W       = 8;
    localparam int GCD_TMO_CYC = 64;

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                o_any = 1'b1;
                o_gnt[(int'(i_ptr) + k) % N_REQ] = 1'b1;
                o_idx = IW'((int'(i_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares a single GCD engine among N_REQ requesters with round-robin grants,
// result return via one-cycle ACK, and a sticky watchdog for a hung engine.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = GCD_W,
    parameter int TMO_CYC = GCD_TMO_CYC
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*W-1:0]       REQ_A,
    input  logic [N_REQ*W-1:0]       REQ_B,
    output logic [N_REQ-1:0]         ACK,
    output logic [W-1:0]             RES_Y,
    output logic                     RES_ERR,
    output logic [$clog2(N_REQ)-1:0] RES_ID,
    output logic                     BUSY,
    output logic                     HANG,
    output logic                     ENG_START,
    output logic [W-1:0]             ENG_A,
    output logic [W-1:0]             ENG_B,
    input  logic [W-1:0]             ENG_Y,
    input  logic                     ENG_DONE,
    input  logic                     ENG_ERROR
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TMO_CYC + 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_id;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res_y;
    logic             r_res_err;
    logic             r_hang;
    logic [CW-1:0]    r_wdog;

    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_grant;
    logic             w_tmo;
    logic [W-1:0]     w_op_a;
    logic [W-1:0]     w_op_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .i_req (REQ),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_grant = (r_state == IDLE) && w_any && !r_hang;
    // The cycle in which the counter would reach TMO_CYC is the last WAIT cycle.
    assign w_tmo   = (r_wdog >= CW'(TMO_CYC - 1));

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op_a = REQ_A[i*W +: W];
                w_op_b = REQ_B[i*W +: W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ACK         = '0;
        ENG_START   = 1'b0;
        BUSY        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ENG_START   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (ENG_DONE || w_tmo) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                ACK[r_id]   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res_y   <= '0;
            r_res_err <= 1'b0;
            r_hang    <= 1'b0;
            r_wdog    <= '0;
        end else begin
            if (w_grant) begin
                r_a      <= w_op_a;
                r_b      <= w_op_b;
                r_id     <= w_idx;
                r_rr_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == ISSUE) begin
                r_wdog <= '0;
            end
            // DONE takes priority over a coincident timeout.
            if (r_state == WAIT) begin
                if (ENG_DONE) begin
                    r_res_y   <= ENG_ERROR ? '0 : ENG_Y;
                    r_res_err <= ENG_ERROR;
                end else begin
                    if (r_wdog != CW'(TMO_CYC)) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                    if (w_tmo) begin
                        r_res_y   <= '0;
                        r_res_err <= 1'b1;
                        r_hang    <= 1'b1;
                    end
                end
            end
        end
    end

    assign RES_Y   = r_res_y;
    assign RES_ERR = r_res_err;
    assign RES_ID  = r_id;
    assign HANG    = r_hang;
    assign ENG_A   = r_a;
    assign ENG_B   = r_b;

endmodule

// File: doc/gcd_sched.md
# gcd_sched

Round-robin scheduler that shares one GCD engine among `N_REQ` requesters. It latches the winning requester's operands and drives the engine's start/operand inputs. It captures the engine's result and error, returns them to the winner with a one-cycle acknowledge, and detects a hung engine with a watchdog. It sits directly between the requester clients and the single GCD engine instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 8: operand/result width; must equal the engine width.
- `TMO_CYC`, 64: watchdog limit, in cycles, spent waiting for engine `DONE`.

Ports:
- `CLK` in 1: clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `REQ` in `N_REQ`: level request per requester; held until its `ACK`.
- `REQ_A` in `N_REQ*W`: operand A per requester; slice i = `[i*W +: W]`; stable while `REQ[i]`=1.
- `REQ_B` in `N_REQ*W`: operand B per requester; same slicing and stability rule.
- `ACK` out `N_REQ`: one-hot, one-cycle pulse; result valid in the same cycle.
- `RES_Y` out `W`: GCD result; forced to 0 when `RES_ERR`=1.
- `RES_ERR` out 1: zero operand or watchdog timeout.
- `RES_ID` out `$clog2(N_REQ)`: index of the requester being acknowledged.
- `BUSY` out 1: high in every state except IDLE.
- `HANG` out 1: sticky watchdog flag; cleared only by reset.
- `ENG_START` out 1: engine start strobe.
- `ENG_A` out `W`: engine operand A.
- `ENG_B` out `W`: engine operand B.
- `ENG_Y` in `W`: engine result.
- `ENG_DONE` in 1: engine completion pulse.
- `ENG_ERROR` in 1: engine zero-operand error.

## Operation
- State IDLE:
  - If any `REQ` bit is set and `HANG`=0, select a winner by round-robin starting at pointer `rr_ptr`.
  - Latch the winner's A, B and id.
  - Set `rr_ptr` = winner+1, mod `N_REQ`.
  - Go to ISSUE.
- State ISSUE:
  - `ENG_START`=1 for exactly one cycle.
  - Go to WAIT and clear the watchdog counter.
- State WAIT:
  - On `ENG_DONE`=1, capture `ENG_Y` and `ENG_ERROR`, then go to RESP.
  - Otherwise increment the watchdog. On reaching `TMO_CYC`, set `RES_ERR`=1 and `RES_Y`=0, set `HANG`=1, and go to RESP.
- State RESP:
  - Drive `ACK[id]`=1 together with `RES_Y`, `RES_ERR` and `RES_ID`.
  - Go to IDLE.
- While `HANG`=1, IDLE issues no grants; only `RST_N` recovers the block.
- `ENG_A`/`ENG_B` carry the latched operands continuously from ISSUE through RESP. The engine re-checks its operand inputs while calculating, so they must not change mid-operation.
- In IDLE, `ENG_A`/`ENG_B` hold their last values; no toggling.
- Requesters deassert `REQ` on the clock edge at which `ACK` is sampled high. The scheduler never samples `REQ` during RESP.
- Operand changes while `REQ` is high are ignored after latching.
- A zero operand is passed to the engine unmodified. The engine's `ERROR` is forwarded and `RES_Y` is forced to 0.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0.
  - `ACK`, `RES_Y`, `RES_ERR`, `RES_ID`, `BUSY`, `HANG`, `ENG_START`, `ENG_A`, `ENG_B` all = 0.
  - Watchdog counter = 0.
- Latency: with `REQ` sampled in IDLE at cycle 0:
  - ISSUE (`ENG_START`) at cycle 1.
  - `ENG_DONE` at cycle 1+k, where k is the engine latency.
  - `ACK` at cycle 2+k.
- Back-to-back: the next grant is decided in the IDLE cycle after RESP, so `ENG_START` never comes sooner than 2 cycles after `ENG_DONE`. The engine has returned to idle by then.
- Simultaneous requests: exactly one grant per IDLE visit; the others wait.
- Fairness bound: a waiting requester is served within `N_REQ` grants.
- `ENG_DONE` is observed only in WAIT. A spurious `ENG_DONE` in any other state is ignored.
- Timeout and `ENG_DONE` in the same cycle: `ENG_DONE` wins; no `HANG`.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); no `ACK` is produced for the aborted request.
- Watchdog counter width: `$clog2(TMO_CYC+1)`; saturating; no wrap.

## Structure
- Package `gcd_pkg`:
  - State enum `sched_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - Default width constant `GCD_W`=8.
  - Default `TMO_CYC` constant.
- Sub-module `rr_arbiter`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, encoded index, and any-request flag.
  - Purely combinational; the pointer register lives in `gcd_sched`.
- Top level holds the FSM, operand/result registers, watchdog, and the `HANG` flag.

## Test plan
- Single request: `REQ[2]`=1, A=48, B=18.
  - Expect `ENG_START` one cycle later and `ACK`=0b0100, `RES_Y`=6, `RES_ERR`=0, `RES_ID`=2.
  - `ACK` occurs exactly 1 cycle after `ENG_DONE`.
- Contention: all four requesters request from reset with operands (12,8), (9,6), (35,14), (17,5).
  - Grants in order 0,1,2,3 with results 4,3,7,1.
  - Requester 0 re-requesting immediately is served after 3.
- Zero operand: `REQ[1]` with A=0, B=20.
  - `RES_ERR`=1, `RES_Y`=0, `ACK[1]` pulse.
  - The next request (A=20, B=15) returns 5 with no error.
- Watchdog: engine model never raises `DONE`, `TMO_CYC`=64.
  - `ACK` with `RES_ERR`=1 occurs 64 cycles after entering WAIT; `HANG`=1.
  - Subsequent `REQ` gets no grant until `RST_N` is pulsed.
- Reset mid-WAIT: assert `RST_N`=0 while WAIT is active.
  - All outputs go to 0 asynchronously; no `ACK`; after release `rr_ptr`=0.
  - The pending request is re-served from requester 0 priority.
